counter_mod_n: RTL
==================

Name: counter_mod_n

Overview:
- Parametrised synchronous modulo-N counter; next generation of the team's fixed 3-bit up counter.
- Adds configurable width and modulus, up/down direction, count enable, parallel load, and a wrap/saturate mode.
- Provides a terminal-count output for cascading and registered wrap/error flags.
- Used as a timebase and sequencer building block in datapath and FSM designs.

Parameters:
WIDTH, 3, counter width in bits; legal range 1..16.
MODULUS, 8, count range 0..MODULUS-1; legal range 2..2^WIDTH; illegal values are an elaboration error.
RESET_VAL, 0, value of Out after reset; must be < MODULUS.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
en  input  1  count enable; the counter steps one position per clk while high.
up_dn  input  1  direction: 1 = up, 0 = down.
sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate at the boundary.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value to load.
Out  output  WIDTH  current count (registered).
tc  output  1  terminal count, combinational: en & (up_dn ? Out==MODULUS-1 : Out==0).
wrapped  output  1  registered one-cycle pulse, asserted the cycle after a wrap occurred.
load_err  output  1  registered one-cycle pulse, asserted the cycle after an out-of-range load.

Behaviour:
- Reset: on a clk edge with rst=1, Out=RESET_VAL, wrapped=0, load_err=0. rst overrides all other inputs.
- Priority per edge: rst > load > en. With none active, Out holds and both pulses return to 0.
- Load:
  - load=1 and load_val < MODULUS: Out=load_val.
  - load=1 and load_val >= MODULUS: Out=MODULUS-1 and load_err=1 next cycle.
  - Load ignores en, up_dn and sat_mode. wrapped=0.
- Count up (en=1, up_dn=1):
  - Out < MODULUS-1: Out+1.
  - Out == MODULUS-1, wrap mode: Out=0, wrapped=1.
  - Out == MODULUS-1, saturate mode: Out holds, wrapped=0.
- Count down (en=1, up_dn=0):
  - Out > 0: Out-1.
  - Out == 0, wrap mode: Out=MODULUS-1, wrapped=1.
  - Out == 0, saturate mode: Out holds.
- Latency: one clk from input to Out. tc has zero latency, so a cascaded stage can use its en = previous stage's tc.
- up_dn and sat_mode may change on any cycle and take effect on the same edge. No internal mode state.
- Arithmetic: compute the next value in WIDTH+1 bits, then compare against MODULUS-1. Out never holds a value >= MODULUS, including when MODULUS = 2^WIDTH.
- rst asserted mid-count or simultaneously with load: the reset result wins and both pulse outputs clear.
- The default parameter set reproduces the legacy 0..7 up-counter sequence with en=1, up_dn=1, sat_mode=0.

Decomposition:
- Shared package counter_pkg:
  - direction constants DIR_UP=1, DIR_DN=0;
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - function clog2 for parameter checks.
- One sub-module, counter_next: purely combinational. Takes Out, up_dn, sat_mode and the modulus; returns next_val, at_bound and will_wrap.
- counter_mod_n keeps the registers, load handling, priority logic and flag registers.

Test Plan:
1. Defaults, rst=1 for 1 clk, then en=1, up_dn=1, 10 clks -> Out 0,1..7,0,1; wrapped high exactly the cycle after 7->0; tc high while Out=7.
2. MODULUS=10, WIDTH=4, down count from RESET_VAL=0, wrap mode -> Out 9,8,...,0,9; wrapped pulses after 0->9; tc high only while Out=0.
3. MODULUS=10, sat_mode=1, load 8, count up 4 clks -> Out 8,9,9,9,9; wrapped never asserts; switch up_dn=0 -> 8,7.
4. MODULUS=10, load with load_val=12 -> Out=9, load_err=1 for exactly 1 clk; load_val=5 with en=1 -> Out=5, no increment.
5. rst and load asserted together mid-count (Out=6, load_val=3) -> Out=RESET_VAL, wrapped=0, load_err=0; en=0 for 3 clks -> Out holds.
6. Two 4-bit MODULUS=10 instances cascaded, stage-2 en = stage-1 tc, 100 clks -> combined count 00..99 back to 00; stage-2 steps only on stage-1 9->0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input longint value);
    int r;
    r = 0;
    for (int i = 0; i < 33; i++) begin
      if ((longint'(1) << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count generator: one step up or down with wrap/saturate
// at the 0 / MODULUS-1 boundaries.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_val,
  output logic             at_bound,
  output logic             will_wrap
);

  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           top_hit;
  logic           bot_hit;

  // The extra bit keeps MODULUS == 2^WIDTH from aliasing back to zero, and
  // the borrow out of the decrement flags the bottom boundary.
  assign cnt_ext = {1'b0, cnt};
  assign inc     = cnt_ext + ONE;
  assign dec     = cnt_ext - ONE;
  assign top_hit = (inc > MAX_VAL);
  assign bot_hit = dec[WIDTH];

  always_comb begin
    next_val  = cnt;
    at_bound  = 1'b0;
    will_wrap = 1'b0;
    if (up_dn == DIR_UP) begin
      at_bound = top_hit;
      if (!top_hit)                   next_val = inc[WIDTH-1:0];
      else if (sat_mode == MODE_WRAP) next_val = '0;
    end else begin
      at_bound = bot_hit;
      if (!bot_hit)                   next_val = dec[WIDTH-1:0];
      else if (sat_mode == MODE_WRAP) next_val = MAX_VAL[WIDTH-1:0];
    end
    will_wrap = at_bound && (sat_mode == MODE_WRAP);
  end

endmodule

// File: rtl/counter_mod_n.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// combinational terminal count and registered wrap / load-error pulses.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Out,
  output logic             tc,
  output logic             wrapped,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("counter_mod_n: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("counter_mod_n: MODULUS must be in 2..2^WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("counter_mod_n: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH:0]   MAX_VAL = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  // Out-of-range loads clamp to the top of the count range.
  function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v,
                                                  input logic oor);
    return oor ? MAX_W : v;
  endfunction

  logic [WIDTH-1:0] next_val;
  logic             at_bound;
  logic             will_wrap;
  logic             load_oor;

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .cnt       (Out),
    .up_dn     (up_dn),
    .sat_mode  (sat_mode),
    .next_val  (next_val),
    .at_bound  (at_bound),
    .will_wrap (will_wrap)
  );

  assign load_oor = ({1'b0, load_val} > MAX_VAL);
  assign tc       = en & at_bound;

  always_ff @(posedge clk) begin
    if (rst) begin
      Out      <= RST_V;
      wrapped  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrapped  <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        Out      <= load_clamp(load_val, load_oor);
        load_err <= load_oor;
      end else if (en) begin
        Out     <= next_val;
        wrapped <= will_wrap;
      end
    end
  end

endmodule
